uart_packet_arbiter_rr: RTL
===========================

// Module: uart_packet_arbiter_rr
// PURPOSE
//  N-input packet arbiter for the shared UART transmit path. Each input feeds a
//  per-channel packet FIFO. A round-robin (or fixed-priority) grant locks one
//  channel from SoP to EoP and forwards its words one at a time to the UART Tx.
//  No packets are interleaved. The FIFOs remove the single-buffer limit, so
//  every contending producer is absorbed without loss.
// PARAMETERS
//  NUM_CH      4   number of input channels (2..8)
//  FIFO_DEPTH  16  words per channel FIFO (power of 2, >=2)
//  PRIO_MODE   0   0 = round-robin, 1 = fixed priority (ch0 highest)
// PORTS
//  ipClk        in   1           system clock; single clock domain
//  ipReset      in   1           reset, asynchronous, active-low
//  ipTxStream   in   UART_PACKET[NUM_CH]  per-channel input words (Valid/SoP/EoP/Data)
//  opTxReady    out  NUM_CH      per-channel accept (= channel FIFO not full)
//  opTxStream   out  UART_PACKET word to UART Tx; Valid is a 1-cycle strobe
//  ipTxReady    in   1           UART Tx idle/ready for next word
//  opGrant      out  $clog2(NUM_CH)  channel currently locked (valid while opBusy)
//  opBusy       out  1           a packet is in flight
//  opOverflow   out  NUM_CH      sticky: a word arrived on a full FIFO and was dropped
// BEHAVIOUR
//  Reset (ipReset=0, async): all FIFOs empty; opTxReady=0; opTxStream.Valid=0;
//   opGrant=0; opBusy=0; opOverflow=0; rr pointer=0; FSM=IDLE. Reset mid-packet
//   drops all buffered data. The first opTxReady rise is 1 cycle after release.
//  Input side: channel i writes when ipTxStream[i].Valid && opTxReady[i]. A write
//   when full is dropped and sets opOverflow[i], which clears only on reset.
//   opTxReady[i] = !full[i], registered. Writes and reads on the same FIFO in the
//   same cycle are both honoured. Count stays constant. Full stays stable.
//  Eligibility: channel i is requesting when its FIFO is non-empty and the head
//   word has SoP=1. A non-SoP head while IDLE is an orphan. It is popped and
//   discarded, one word per cycle, without a grant.
//  FSM:
//   IDLE  : if any request, grant the winner. Round-robin searches from rr pointer
//           upward with wrap; fixed priority picks the lowest index.
//           opGrant <= winner, opBusy <= 1 -> SEND.
//   SEND  : if ipTxReady && FIFO[grant] non-empty, opTxStream <= head with
//           Valid=1 for exactly 1 cycle, pop, latch lastEoP <= head.EoP
//           -> WAIT_ACK. If the FIFO is empty (producer slower than UART),
//           stall in SEND with Valid=0.
//   WAIT_ACK: Valid=0; wait for ipTxReady=0 (UART accepted). Then, if lastEoP,
//           rr pointer <= grant+1 (mod NUM_CH), opBusy <= 0 -> IDLE; else -> SEND.
//  A SoP seen inside a locked packet (missing EoP) is forwarded as data. Framing
//   is the producer's responsibility.
//  Latency: SoP write -> opTxStream.Valid >= 3 cycles (write, IDLE grant, SEND).
//  Minimum inter-word spacing is set by the UART ready handshake. The next grant
//   decision is made in the cycle after EoP is acknowledged.
//  Simultaneous SoP heads on all channels: round-robin serves them in pointer
//   order. Each channel gets one packet per round. No starvation in mode 0.
//  Width rules: FIFO pointers are $clog2(FIFO_DEPTH)+1 bits, and the MSB
//   distinguishes full from empty. rr pointer wraps NUM_CH-1 -> 0 for
//   non-power-of-2 NUM_CH.
// STRUCTURE
//  Shared package Structures: UART_PACKET (existing); typedef ARB_STATE
//   {IDLE, SEND, WAIT_ACK}.
//  Sub-module uart_packet_fifo (depth param, UART_PACKET wide, push/pop/full/
//   empty/head, async active-low reset). It is instantiated NUM_CH times in a
//   generate loop. Arbitration and the FSM stay in the top module.
// TESTING
//  1 Single channel: ch2 sends 3-word packet (SoP 0x41, 0x42, EoP 0x43), UART
//    ack model 4 cycles -> 3 Valid strobes in order, opGrant=2, opBusy falls
//    after 0x43 ack.
//  2 Contention: all 4 channels load a 2-word packet in the same cycle ->
//    output order ch0,ch1,ch2,ch3, no interleave. Next round starts at ch0.
//  3 Fixed priority (PRIO_MODE=1): ch3 packet pending, ch1 SoP arrives mid-ch3
//    packet -> ch3 completes. ch1 is granted before any later ch3 packet.
//  4 Overflow: ch0 writes 18 words with FIFO_DEPTH=16 and UART held not-ready ->
//    opTxReady[0]=0 after word 16, words 17-18 dropped, opOverflow[0]=1.
//  5 Orphan/stall: ch1 head non-SoP 0x55 -> discarded, no grant. A granted
//    packet whose FIFO runs empty -> Valid stays 0 until data arrives, then
//    the packet resumes.
//  6 Reset mid-packet: assert ipReset low during WAIT_ACK -> all outputs hit
//    reset values at once. Fresh packet after release is sent intact.

Source files
------------

// File: rtl/uart_packet_arbiter_rr_pkg.sv
// ============================================================================
// uart_packet_arbiter_rr_pkg : shared packet word type and arbiter FSM states
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package uart_packet_arbiter_rr_pkg;

   typedef struct packed {
      logic       Valid;
      logic       SoP;
      logic       EoP;
      logic [7:0] Data;
   } UART_PACKET;

   typedef logic [1:0] ARB_STATE;

   localparam ARB_STATE IDLE     = 2'd0;
   localparam ARB_STATE SEND     = 2'd1;
   localparam ARB_STATE WAIT_ACK = 2'd2;

endpackage

`default_nettype wire

// File: rtl/uart_packet_arbiter_rr_fifo.sv
// ============================================================================
// uart_packet_fifo : per-channel packet word FIFO with registered not-full flag
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_packet_fifo
   import uart_packet_arbiter_rr_pkg::*;
#(
   parameter int DEPTH = 16
)
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push,
   input  UART_PACKET push_word,
   input  logic       pop,
   output UART_PACKET head,
   output logic       full,
   output logic       empty,
   output logic       ready
);

   localparam int AW = $clog2(DEPTH);

   UART_PACKET mem [DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic [AW:0] wr_ptr_nxt;
   logic [AW:0] rd_ptr_nxt;
   logic        do_push;
   logic        do_pop;
   logic        full_nxt;

   assign do_push    = push && !full;
   assign do_pop     = pop && !empty;
   assign wr_ptr_nxt = wr_ptr + {{AW{1'b0}}, do_push};
   assign rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, do_pop};

   // Pointer MSB differs and index bits match: the write side has lapped the read side
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty    = (wr_ptr == rd_ptr);
   assign full_nxt = (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                     (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);
   assign head     = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr[AW-1:0]] <= push_word;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         ready  <= 1'b0;
      end else begin
         wr_ptr <= wr_ptr_nxt;
         rd_ptr <= rd_ptr_nxt;
         ready  <= !full_nxt;
      end
   end

endmodule

`default_nettype wire

// File: rtl/uart_packet_arbiter_rr.sv
// ============================================================================
// uart_packet_arbiter_rr : N-channel packet arbiter feeding one UART Tx path
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_packet_arbiter_rr
   import uart_packet_arbiter_rr_pkg::*;
#(
   parameter int NUM_CH     = 4,
   parameter int FIFO_DEPTH = 16,
   parameter int PRIO_MODE  = 0
)
(
   input  logic                        ipClk,
   input  logic                        ipReset,
   input  UART_PACKET [NUM_CH-1:0]     ipTxStream,
   output logic [NUM_CH-1:0]           opTxReady,
   output UART_PACKET                  opTxStream,
   input  logic                        ipTxReady,
   output logic [$clog2(NUM_CH)-1:0]   opGrant,
   output logic                        opBusy,
   output logic [NUM_CH-1:0]           opOverflow
);

   localparam int GW = $clog2(NUM_CH);
   localparam logic [GW:0]   NCH_W   = (GW+1)'(NUM_CH);
   localparam logic [GW-1:0] LAST_CH = GW'(NUM_CH - 1);

   UART_PACKET [NUM_CH-1:0] head;
   logic [NUM_CH-1:0] push;
   logic [NUM_CH-1:0] pop;
   logic [NUM_CH-1:0] full;
   logic [NUM_CH-1:0] empty;
   logic [NUM_CH-1:0] in_valid;
   logic [NUM_CH-1:0] req;
   logic [NUM_CH-1:0] orphan;

   ARB_STATE      state;
   logic [GW-1:0] rr_ptr;
   logic [GW-1:0] winner;
   logic [GW:0]   cand;
   logic          found;
   logic          last_eop;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign in_valid[i] = ipTxStream[i].Valid;
      assign push[i]     = ipTxStream[i].Valid && opTxReady[i];
      assign req[i]      = !empty[i] && head[i].SoP;
      assign orphan[i]   = !empty[i] && !head[i].SoP;

      uart_packet_fifo #(
         .DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .clk       (ipClk),
         .rst_n     (ipReset),
         .push      (push[i]),
         .push_word (ipTxStream[i]),
         .pop       (pop[i]),
         .head      (head[i]),
         .full      (full[i]),
         .empty     (empty[i]),
         .ready     (opTxReady[i])
      );
   end

   // Candidate k is rr_ptr+k (wrapped) in round-robin mode, plain k in fixed priority
   always_comb begin
      winner = '0;
      found  = 1'b0;
      cand   = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (PRIO_MODE != 0) begin
            cand = (GW+1)'(k);
         end else begin
            cand = {1'b0, rr_ptr} + (GW+1)'(k);
         end
         if (cand >= NCH_W) begin
            cand = cand - NCH_W;
         end
         if (!found && req[cand[GW-1:0]]) begin
            found  = 1'b1;
            winner = cand[GW-1:0];
         end
      end
   end

   // Orphan heads are flushed only while idle; inside a packet every word is data
   always_comb begin
      pop = '0;
      if (state == IDLE) begin
         pop = orphan;
      end else if ((state == SEND) && ipTxReady && !empty[opGrant]) begin
         pop[opGrant] = 1'b1;
      end
   end

   always_ff @(posedge ipClk or negedge ipReset) begin
      if (!ipReset) begin
         opOverflow <= '0;
      end else begin
         opOverflow <= opOverflow | (in_valid & full);
      end
   end

   always_ff @(posedge ipClk or negedge ipReset) begin
      if (!ipReset) begin
         state      <= IDLE;
         opGrant    <= '0;
         opBusy     <= 1'b0;
         rr_ptr     <= '0;
         last_eop   <= 1'b0;
         opTxStream <= '0;
      end else begin
         opTxStream.Valid <= 1'b0;
         case (state)
            IDLE: begin
               if (found) begin
                  opGrant <= winner;
                  opBusy  <= 1'b1;
                  state   <= SEND;
               end
            end
            SEND: begin
               if (ipTxReady && !empty[opGrant]) begin
                  opTxStream       <= head[opGrant];
                  opTxStream.Valid <= 1'b1;
                  last_eop         <= head[opGrant].EoP;
                  state            <= WAIT_ACK;
               end
            end
            WAIT_ACK: begin
               if (!ipTxReady) begin
                  if (last_eop) begin
                     rr_ptr <= (opGrant == LAST_CH) ? '0 : opGrant + 1'b1;
                     opBusy <= 1'b0;
                     state  <= IDLE;
                  end else begin
                     state  <= SEND;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire
